// File: rtl/rx_cntrl_pkg.sv
// Shared types and defaults for the SPI test-link receive-side frame checker.
package rx_cntrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } rx_state_e;

    localparam int unsigned EXP_WORD_DEF = 3000;
    localparam int unsigned TIMEOUT_DEF  = 70000;

endpackage

// File: rtl/sat_cntr.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_cntr #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] q
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/rx_cntrl.sv
// Far-end frame checker: expects exactly one EXP_WORD per spi_rst frame and keeps
// saturating match/error/timeout statistics plus a lock indicator.
module rx_cntrl
    import rx_cntrl_pkg::*;
#(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned EXP_WORD    = EXP_WORD_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_DEF,
    parameter int unsigned LOCK_N      = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              spi_rst,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_dv,
    input  logic              clr_stats,
    output logic [DATA_W-1:0] word_out,
    output logic              word_valid,
    output logic [CNT_W-1:0]  match_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  timeout_cnt,
    output logic              locked,
    output logic              err_flag
);

    localparam int unsigned WD_W  = $clog2(TIMEOUT_CYC);
    localparam int unsigned RUN_W = $clog2(LOCK_N + 1);

    localparam logic [DATA_W-1:0] EXP_VAL = DATA_W'(EXP_WORD);
    localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [RUN_W-1:0]  RUN_MAX = RUN_W'(LOCK_N);

    rx_state_e         state_q, state_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic              locked_q, locked_d;
    logic              err_flag_q, err_flag_d;
    logic [DATA_W-1:0] cmp_q, cmp_d;
    logic              pend_q, pend_d;
    logic              extra_q, extra_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic              wv_q;

    logic match_inc;
    logic err_inc;
    logic wd_expire;
    logic run_clr;

    always_comb begin
        state_d   = state_q;
        cmp_d     = cmp_q;
        pend_d    = pend_q;
        extra_d   = 1'b0;
        run_d     = run_q;
        locked_d  = locked_q;
        match_inc = 1'b0;
        // Extra words are flagged one cycle late so every error lands two cycles after rx_dv.
        err_inc   = extra_q;
        run_clr   = extra_q;
        wd_expire = 1'b0;
        wd_d      = (state_q == IDLE || spi_rst) ? '0 : wd_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (spi_rst) state_d = ARMED;
                if (rx_dv)   extra_d = 1'b1;
            end
            ARMED: begin
                if (rx_dv) begin
                    cmp_d   = rx_data;
                    pend_d  = spi_rst;
                    state_d = CHECK;
                end else if (spi_rst) begin
                    err_inc = 1'b1;
                    run_clr = 1'b1;
                end
            end
            CHECK: begin
                if (cmp_q == EXP_VAL) begin
                    match_inc = 1'b1;
                end else begin
                    err_inc = 1'b1;
                    run_clr = 1'b1;
                end
                state_d = (spi_rst || pend_q) ? ARMED : DONE;
                pend_d  = 1'b0;
                if (rx_dv) extra_d = 1'b1;
            end
            DONE: begin
                if (spi_rst) state_d = ARMED;
                if (rx_dv)   extra_d = 1'b1;
            end
        endcase

        // A frame boundary arriving on the last watchdog cycle still counts as in time.
        if (state_q != IDLE && !spi_rst && wd_q == WD_LAST) begin
            wd_expire = 1'b1;
            state_d   = IDLE;
            wd_d      = '0;
            pend_d    = 1'b0;
            run_clr   = 1'b1;
        end

        if (run_clr) begin
            run_d    = '0;
            locked_d = 1'b0;
        end else if (match_inc) begin
            if (run_q >= RUN_MAX - 1'b1) begin
                run_d    = RUN_MAX;
                locked_d = 1'b1;
            end else begin
                run_d = run_q + 1'b1;
            end
        end

        if (clr_stats) begin
            err_flag_d = 1'b0;
        end else if (err_inc || wd_expire) begin
            err_flag_d = 1'b1;
        end else begin
            err_flag_d = err_flag_q;
        end

        word_d = rx_dv ? rx_data : word_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            wd_q       <= '0;
            run_q      <= '0;
            locked_q   <= 1'b0;
            err_flag_q <= 1'b0;
            cmp_q      <= '0;
            pend_q     <= 1'b0;
            extra_q    <= 1'b0;
            word_q     <= '0;
            wv_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            wd_q       <= wd_d;
            run_q      <= run_d;
            locked_q   <= locked_d;
            err_flag_q <= err_flag_d;
            cmp_q      <= cmp_d;
            pend_q     <= pend_d;
            extra_q    <= extra_d;
            word_q     <= word_d;
            wv_q       <= rx_dv;
        end
    end

    sat_cntr #(.CNT_W(CNT_W)) u_match_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (match_inc),
        .clr     (clr_stats),
        .q       (match_cnt)
    );

    sat_cntr #(.CNT_W(CNT_W)) u_err_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (err_inc),
        .clr     (clr_stats),
        .q       (err_cnt)
    );

    sat_cntr #(.CNT_W(CNT_W)) u_timeout_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (wd_expire),
        .clr     (clr_stats),
        .q       (timeout_cnt)
    );

    assign word_out   = word_q;
    assign word_valid = wv_q;
    assign locked     = locked_q;
    assign err_flag   = err_flag_q;

endmodule

// File: tb/tb_rx_cntrl.sv
// Directed bench for rx_cntrl: per-cycle vector table plus hand sequences for
// watchdog expiry, asynchronous reset and counter saturation.
module tb_rx_cntrl;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned TIMEOUT = 200;
    localparam int unsigned CNT_W   = 4;

    logic              clk;
    logic              reset_n;
    logic              spi_rst;
    logic [DATA_W-1:0] rx_data;
    logic              rx_dv;
    logic              clr_stats;
    logic [DATA_W-1:0] word_out;
    logic              word_valid;
    logic [CNT_W-1:0]  match_cnt;
    logic [CNT_W-1:0]  err_cnt;
    logic [CNT_W-1:0]  timeout_cnt;
    logic              locked;
    logic              err_flag;

    int checks = 0;
    int errors = 0;

    rx_cntrl #(
        .DATA_W      (DATA_W),
        .EXP_WORD    (3000),
        .TIMEOUT_CYC (TIMEOUT),
        .LOCK_N      (4),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .spi_rst     (spi_rst),
        .rx_data     (rx_data),
        .rx_dv       (rx_dv),
        .clr_stats   (clr_stats),
        .word_out    (word_out),
        .word_valid  (word_valid),
        .match_cnt   (match_cnt),
        .err_cnt     (err_cnt),
        .timeout_cnt (timeout_cnt),
        .locked      (locked),
        .err_flag    (err_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              spi;
        logic              dv;
        logic [DATA_W-1:0] data;
        logic              clr;
        logic              wv;
        logic [DATA_W-1:0] wo;
        logic [CNT_W-1:0]  m;
        logic [CNT_W-1:0]  e;
        logic              lk;
        logic              ef;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int s, input int d, input int data, input int c,
                                input int wv, input int wo, input int m, input int e,
                                input int lk, input int ef);
        vec_t r;
        r.spi  = 1'(s);
        r.dv   = 1'(d);
        r.data = (d != 0) ? DATA_W'(data) : 16'h5A5A;
        r.clr  = 1'(c);
        r.wv   = 1'(wv);
        r.wo   = DATA_W'(wo);
        r.m    = CNT_W'(m);
        r.e    = CNT_W'(e);
        r.lk   = 1'(lk);
        r.ef   = 1'(ef);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic d, input logic [DATA_W-1:0] data, input logic c);
        spi_rst   = s;
        rx_dv     = d;
        rx_data   = data;
        clr_stats = c;
    endtask

    initial begin
        //        S  D  data  C  wv wo    m  e  lk ef
        vecs.push_back(mk(1, 0, 0,    0, 0, 0,    0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 3000, 0, 1, 3000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,    0, 0, 3000, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0,    0, 0, 3000, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 3000, 0, 1, 3000, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,    0, 0, 3000, 2, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0,    0, 0, 3000, 2, 0, 0, 0));
        vecs.push_back(mk(0, 1, 3000, 0, 1, 3000, 2, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,    0, 0, 3000, 3, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0,    0, 0, 3000, 3, 0, 0, 0));
        vecs.push_back(mk(0, 1, 3000, 0, 1, 3000, 3, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,    0, 0, 3000, 4, 0, 1, 0));
        // bad word drops lock
        vecs.push_back(mk(1, 0, 0,    0, 0, 3000, 4, 0, 1, 0));
        vecs.push_back(mk(0, 1, 2999, 0, 1, 2999, 4, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0,    0, 0, 2999, 4, 1, 0, 1));
        // missing word: two frame starts with no rx_dv between them
        vecs.push_back(mk(1, 0, 0,    0, 0, 2999, 4, 1, 0, 1));
        vecs.push_back(mk(1, 0, 0,    0, 0, 2999, 4, 2, 0, 1));
        vecs.push_back(mk(0, 1, 3000, 0, 1, 3000, 4, 2, 0, 1));
        vecs.push_back(mk(0, 0, 0,    0, 0, 3000, 5, 2, 0, 1));
        // extra word in DONE
        vecs.push_back(mk(0, 1, 3000, 0, 1, 3000, 5, 2, 0, 1));
        vecs.push_back(mk(0, 0, 0,    0, 0, 3000, 5, 3, 0, 1));
        // rx_dv with spi_rst in ARMED: counted for old frame, then ARMED again
        vecs.push_back(mk(1, 0, 0,    0, 0, 3000, 5, 3, 0, 1));
        vecs.push_back(mk(1, 1, 3000, 0, 1, 3000, 5, 3, 0, 1));
        vecs.push_back(mk(0, 0, 0,    0, 0, 3000, 6, 3, 0, 1));
        vecs.push_back(mk(1, 0, 0,    0, 0, 3000, 6, 4, 0, 1));
        // clr_stats coincident with a match
        vecs.push_back(mk(0, 1, 3000, 0, 1, 3000, 6, 4, 0, 1));
        vecs.push_back(mk(0, 0, 0,    1, 0, 3000, 0, 0, 0, 0));
        // relock: run counter kept its 1 across the clear
        vecs.push_back(mk(1, 0, 0,    0, 0, 3000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 3000, 0, 1, 3000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,    0, 0, 3000, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0,    0, 0, 3000, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 3000, 0, 1, 3000, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,    0, 0, 3000, 2, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0,    0, 0, 3000, 2, 0, 0, 0));
        vecs.push_back(mk(0, 1, 3000, 0, 1, 3000, 2, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,    0, 0, 3000, 3, 0, 1, 0));

        reset_n = 1'b0;
        drive(1'b0, 1'b0, '0, 1'b0);
        tick();
        tick();
        chk("reset word_out", 32'(word_out), 0);
        chk("reset word_valid", 32'(word_valid), 0);
        chk("reset match_cnt", 32'(match_cnt), 0);
        chk("reset err_cnt", 32'(err_cnt), 0);
        chk("reset timeout_cnt", 32'(timeout_cnt), 0);
        chk("reset locked", 32'(locked), 0);
        chk("reset err_flag", 32'(err_flag), 0);
        reset_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            drive(vecs[i].spi, vecs[i].dv, vecs[i].data, vecs[i].clr);
            tick();
            chk($sformatf("row%0d word_valid", i), 32'(word_valid), 32'(vecs[i].wv));
            chk($sformatf("row%0d word_out", i), 32'(word_out), 32'(vecs[i].wo));
            chk($sformatf("row%0d match_cnt", i), 32'(match_cnt), 32'(vecs[i].m));
            chk($sformatf("row%0d err_cnt", i), 32'(err_cnt), 32'(vecs[i].e));
            chk($sformatf("row%0d locked", i), 32'(locked), 32'(vecs[i].lk));
            chk($sformatf("row%0d err_flag", i), 32'(err_flag), 32'(vecs[i].ef));
            chk($sformatf("row%0d timeout_cnt", i), 32'(timeout_cnt), 0);
        end

        // Watchdog: last frame start, then silence until expiry.
        drive(1'b1, 1'b0, '0, 1'b1);
        tick();
        drive(1'b0, 1'b0, '0, 1'b0);
        repeat (TIMEOUT - 1) tick();
        chk("wd before expiry timeout_cnt", 32'(timeout_cnt), 0);
        chk("wd before expiry locked", 32'(locked), 1);
        chk("wd before expiry err_flag", 32'(err_flag), 0);
        tick();
        chk("wd expiry timeout_cnt", 32'(timeout_cnt), 1);
        chk("wd expiry locked", 32'(locked), 0);
        chk("wd expiry err_flag", 32'(err_flag), 1);
        chk("wd expiry err_cnt", 32'(err_cnt), 0);
        drive(1'b0, 1'b1, 16'd1234, 1'b0);
        tick();
        drive(1'b0, 1'b0, '0, 1'b0);
        tick();
        chk("idle extra err_cnt", 32'(err_cnt), 1);
        chk("idle extra word_out", 32'(word_out), 1234);
        repeat (TIMEOUT + 50) tick();
        chk("idle no rerun timeout_cnt", 32'(timeout_cnt), 1);
        chk("idle no rerun err_cnt", 32'(err_cnt), 1);

        // Asynchronous reset in the middle of ARMED.
        drive(1'b1, 1'b0, '0, 1'b0);
        tick();
        drive(1'b0, 1'b0, '0, 1'b0);
        repeat (5) tick();
        #3;
        reset_n = 1'b0;
        #1;
        chk("async rst word_out", 32'(word_out), 0);
        chk("async rst word_valid", 32'(word_valid), 0);
        chk("async rst match_cnt", 32'(match_cnt), 0);
        chk("async rst err_cnt", 32'(err_cnt), 0);
        chk("async rst timeout_cnt", 32'(timeout_cnt), 0);
        chk("async rst locked", 32'(locked), 0);
        chk("async rst err_flag", 32'(err_flag), 0);
        tick();
        reset_n = 1'b1;
        repeat (TIMEOUT + 100) tick();
        chk("post rst idle timeout_cnt", 32'(timeout_cnt), 0);
        chk("post rst idle err_cnt", 32'(err_cnt), 0);
        chk("post rst idle match_cnt", 32'(match_cnt), 0);
        drive(1'b1, 1'b0, '0, 1'b0);
        tick();
        drive(1'b0, 1'b1, 16'd3000, 1'b0);
        tick();
        drive(1'b0, 1'b0, '0, 1'b0);
        tick();
        chk("post rst frame match_cnt", 32'(match_cnt), 1);
        chk("post rst frame err_cnt", 32'(err_cnt), 0);

        // Saturation: 20 good frames into a 4-bit counter.
        drive(1'b0, 1'b0, '0, 1'b1);
        tick();
        for (int f = 0; f < 20; f++) begin
            drive(1'b1, 1'b0, '0, 1'b0);
            tick();
            drive(1'b0, 1'b1, 16'd3000, 1'b0);
            tick();
            drive(1'b0, 1'b0, '0, 1'b0);
            tick();
        end
        chk("sat match_cnt", 32'(match_cnt), 15);
        chk("sat err_cnt", 32'(err_cnt), 0);
        chk("sat locked", 32'(locked), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_cntrl.md
Name: rx_cntrl

Overview:
- Far-end controller for the SPI test link; the mirror of the transmit-side pattern generator.
- Watches the frame-start pulse (spi_rst) and received words (rx_data/rx_dv) coming out of the SPI receiver.
- Checks that exactly one word equal to EXP_WORD arrives per frame.
- Keeps saturating match/error/timeout statistics and a lock indicator for bring-up and ILA probing.

Parameters:
- DATA_W, 16: received word width.
- EXP_WORD, 3000: expected payload value of each frame.
- TIMEOUT_CYC, 70000: cycles allowed between spi_rst pulses before a timeout is declared; must exceed the 65536-cycle frame period.
- LOCK_N, 4: consecutive good frames required to assert locked.
- CNT_W, 16: statistics counter width.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- spi_rst  in  1  one-cycle frame-start pulse from the link
- rx_data  in  DATA_W  received word
- rx_dv  in  1  one-cycle strobe; rx_data is valid while high
- clr_stats  in  1  synchronous clear of counters and err_flag
- word_out  out  DATA_W  last received word, registered
- word_valid  out  1  one-cycle pulse, one cycle after rx_dv
- match_cnt  out  CNT_W  frames whose word matched EXP_WORD
- err_cnt  out  CNT_W  mismatched, missing or extra words
- timeout_cnt  out  CNT_W  watchdog expiries
- locked  out  1  LOCK_N consecutive good frames seen
- err_flag  out  1  sticky; set on any error or timeout

Behaviour:
- Reset (reset_n low, asynchronous):
  - all outputs 0, state IDLE, watchdog 0, good-frame run counter 0.
- States: IDLE, ARMED, CHECK, DONE.
  - IDLE: waits for spi_rst, then goes to ARMED and clears the watchdog. rx_dv in IDLE counts as an extra word: err_cnt+1, err_flag set.
  - ARMED: waits for rx_dv. rx_dv captures rx_data into a compare register and goes to CHECK. spi_rst with no rx_dv means a missing word: err_cnt+1, run counter cleared, locked cleared, stay in ARMED, watchdog cleared.
  - CHECK (one cycle):
    - word == EXP_WORD: match_cnt+1, run counter+1 (saturating at LOCK_N); locked set when the run counter reaches LOCK_N.
    - otherwise: err_cnt+1, run counter 0, locked 0, err_flag set.
    - Then go to DONE. If spi_rst arrives in the same cycle, go to ARMED instead and clear the watchdog.
  - DONE: spi_rst goes to ARMED and clears the watchdog. rx_dv is an extra word: err_cnt+1, locked 0, run counter 0.
- Simultaneous rx_dv and spi_rst in ARMED: the word belongs to the ending frame. Go to CHECK; CHECK then goes straight to ARMED because the pending spi_rst is recorded in a one-bit flag.
- Watchdog:
  - Counts every cycle outside IDLE; cleared on each spi_rst.
  - On reaching TIMEOUT_CYC-1: timeout_cnt+1, locked 0, run counter 0, err_flag set, state IDLE.
  - Width is clog2(TIMEOUT_CYC).
- word_out/word_valid: word_out is rx_data registered on rx_dv in every state; word_valid pulses the cycle after rx_dv. Latency 1.
- Statistics counters: latency 2 from rx_dv. They saturate at all-ones and never wrap.
- clr_stats: zeroes match_cnt, err_cnt, timeout_cnt and err_flag. It wins over a same-cycle increment. It does not affect the state, locked or the watchdog.
- Reset asserted mid-frame aborts immediately. After release, the block waits in IDLE for the next spi_rst; any partial frame is discarded without being counted.

Decomposition:
- Package rx_cntrl_pkg:
  - state enum (IDLE, ARMED, CHECK, DONE), 2-bit encoding;
  - default constants EXP_WORD_DEF=3000, TIMEOUT_DEF=70000.
- Sub-module sat_cntr (parameter CNT_W; inputs inc, clr; output q; clear has priority over increment). Instantiated three times.

Test Plan:
- Nominal: spi_rst at cycle 10, rx_dv with 3000 at cycle 3010, repeated every 65536 cycles for 5 frames -> match_cnt=5, err_cnt=0, locked high from the 4th CHECK, word_valid at 3011.
- Bad word: third frame carries 2999 -> err_cnt=1, locked drops at that CHECK, err_flag=1; relocks after 4 further good frames.
- Missing/extra word:
  - frame with no rx_dv -> err_cnt+1 at the next spi_rst;
  - frame with two rx_dv pulses -> err_cnt+1 on the second; match_cnt+1 only for the first.
- Timeout: spi_rst stops after frame 2 -> timeout_cnt=1 exactly 70000 cycles after the last spi_rst, state IDLE, locked 0. An rx_dv afterwards -> err_cnt+1.
- Collisions:
  - rx_dv and spi_rst in the same cycle in ARMED -> word counted against the old frame, state ARMED two cycles later;
  - clr_stats coincident with a match -> match_cnt reads 0.
- Saturation/reset:
  - CNT_W=4, 20 good frames -> match_cnt=15;
  - reset_n pulsed low mid-ARMED -> all outputs 0 asynchronously, no count on recovery until the next full frame.
